// File: rtl/rr_encoder16_pkg.sv
// Shared constants for the round-robin request encoder: default sizes and FSM state codes.
package rr_encoder16_pkg;

    localparam int N_DEF = 16;
    localparam int W_DEF = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/rr_encoder16_pick.sv
// Combinational round-robin picker: lowest set request at or above ptr, wrapping to the bottom.
module rr_pick
    import rr_encoder16_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] winner_o,
    output logic         any_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   idx;

    // Rotate so ptr lands on bit 0, fixed-priority encode, then add ptr back (mod N).
    always_comb begin
        dbl = {req_i, req_i} >> ptr_i;
        rot = dbl[N-1:0];
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) idx = W'(i);
        end
        winner_o = idx + ptr_i;
    end

    assign any_o = |req_i;

endmodule

// File: rtl/rr_encoder16.sv
// Round-robin 16-to-4 request encoder with registered valid/ready output.
// Optional multi-hot flag enabled by defining MULTI_DETECT_EN.
module rr_encoder16
    import rr_encoder16_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] code,
    output logic         multi,
    output logic [0:0]   dbg_state,
    output logic [W-1:0] dbg_ptr
);

    // Handshake: a code transfers on any rising edge where out_valid and out_ready are both 1;
    // while out_valid is 1 and out_ready is 0, code and multi are held unchanged.

    logic [0:0]   state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] code_q, code_d;
    logic         valid_q, valid_d;
    logic         multi_q, multi_d;

    logic         xfer;
    logic [W-1:0] ptr_next;
    logic [W-1:0] search_ptr;
    logic [W-1:0] winner;
    logic         any;
    logic         multi_now;

    assign xfer       = (state_q == ST_HOLD) && out_ready;
    assign ptr_next   = code_q + {{(W-1){1'b0}}, 1'b1};
    // A capture on the transfer edge must search from the already-advanced pointer.
    assign search_ptr = xfer ? ptr_next : ptr_q;

    rr_pick #(.N(N), .W(W)) u_pick (
        .req_i    (req),
        .ptr_i    (search_ptr),
        .winner_o (winner),
        .any_o    (any)
    );

`ifdef MULTI_DETECT_EN
    assign multi_now = |(req & (req - {{(N-1){1'b0}}, 1'b1}));
`else
    assign multi_now = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        code_d  = code_q;
        valid_d = valid_q;
        multi_d = multi_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    code_d  = winner;
                    valid_d = 1'b1;
                    multi_d = multi_now;
                    state_d = ST_HOLD;
                end
            end
            default: begin
                if (xfer) begin
                    ptr_d = ptr_next;
                    if (any) begin
                        code_d  = winner;
                        multi_d = multi_now;
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign out_valid = valid_q;
    assign code      = code_q;
    assign multi     = multi_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

endmodule
